adder_5b: RTL and testbench
===========================

// Module: adder_5b
// PURPOSE
//   Unsigned 5-bit + 5-bit adder with a 6-bit result, exposed as individual bit ports.
//   The combinational sum (q5..q0) settles within the same time step as its operands.
//   A registered copy of the sum (sum_r) is provided for clocked consumers.
//   Leaf arithmetic block; no handshake, always valid.
// PARAMETERS
//   none; operand width fixed at 5 (OPW=5, SUMW=6 from adder_pkg)
// PORTS
//   clk     in   1  clock; sum_r updates on rising edge
//   rst     in   1  reset, asynchronous, active-high
//   a4..a0  in   1  operand A bits, a4 = MSB
//   b4..b0  in   1  operand B bits, b4 = MSB
//   q5..q0  out  1  combinational sum bits; q5 = carry-out, q0 = LSB
//   sum_r   out  6  registered {q5..q0}
// BEHAVIOUR
//   - {q5,q4,q3,q2,q1,q0} = {a4..a0} + {b4..b0}, zero-extended to 6 bits.
//   - Modulo arithmetic never applies; the 6-bit result always holds the exact sum
//     (max 31+31=62).
//   - q* is purely combinational: zero-cycle latency, no dependence on clk/rst,
//     defined whenever inputs are 0/1.
//   - Chain per bit i: q[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]);
//     c[0] = 0; q5 = c[5].
//   - sum_r: rst=1 -> 6'd0 immediately (async), held while rst=1.
//     Otherwise sum_r <= {q5..q0} on each rising clk, giving 1-cycle latency.
//   - Reset deasserting mid-stream: first captured value is the sum present at the
//     first rising edge after release.
//   - Reset never affects q*.
//   - X/Z on any input may propagate; no X-masking.
// CONFIGURATION
//   ADDER_CLA_EN defined: carries c1..c5 come from 2-level carry-lookahead.
//     g=a&b, p=a^b; c[i+1] = g[i] | p[i]&g[i-1] | ... | p[i]&..&p[0]&c0.
//   Not defined: ripple chain of full_adder instances.
//   Both variants are bit-identical on every output for all 1024 input pairs;
//   only the timing structure differs.
// STRUCTURE
//   - adder_pkg holds:
//       localparams OPW=5 and SUMW=6
//       typedef logic [OPW-1:0] operand_t
//       typedef logic [SUMW-1:0] sum_t
//       function cla_carry(g, p, cin)
//   - Sub-module full_adder (a, b, ci -> s, co).
//     Instantiated 5x via generate in ripple mode.
//     Sum bits in CLA mode are still s = p ^ c.
//   - Bit ports are packed into operand_t internally and unpacked to q* at the boundary.
// TESTING
//   - a=0,b=0 -> q=6'd0; a=1,b=1 -> q=6'd2; a=3,b=3 -> q=6'd6 (sampled #1 after apply).
//   - a=31,b=1 -> q=6'd32 (full carry ripple, q5=1, q4..q0=0).
//   - a=31,b=31 -> q=6'd62; a=21,b=10 -> q=6'd31 (no carries).
//   - Exhaustive loop, all 32x32 pairs, both with and without ADDER_CLA_EN:
//     q === a+b, else report FAIL and stop.
//   - rst=1 mid-run with a=7,b=9 -> sum_r=0 without a clk edge, q=16 unaffected.
//   - After release, next rising edge -> sum_r=16.
//   - Change a=2,b=5 between edges -> q=7 immediately, sum_r=7 only after next rising edge.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: widths, operand/sum types and the lookahead carry helper
// shared by adder_5b (ADDER_CLA_EN selects lookahead carries in the top).
package adder_pkg;

  localparam int OPW  = 5;
  localparam int SUMW = 6;

  typedef logic [OPW-1:0]  operand_t;
  typedef logic [SUMW-1:0] sum_t;

  // Flat sum-of-products carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin.
  // Returns {c5..c0}, with c0 = cin.
  function automatic sum_t cla_carry(
    input operand_t g,
    input operand_t p,
    input logic     cin
  );
    sum_t c;
    logic acc;
    logic pp;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < OPW; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      acc      = acc | (pp & cin);
      c[i + 1] = acc;
    end
    return c;
  endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit sum and carry cell used by the ripple build
// of adder_5b.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);

endmodule

// File: rtl/adder_5b.sv
// adder_5b: 5b+5b unsigned adder, bit ports, plus a registered copy.
// Define ADDER_CLA_EN for lookahead carries; default is a ripple chain.
import adder_pkg::*;

module adder_5b (
  input  logic       clk,
  input  logic       rst,
  input  logic       a4,
  input  logic       a3,
  input  logic       a2,
  input  logic       a1,
  input  logic       a0,
  input  logic       b4,
  input  logic       b3,
  input  logic       b2,
  input  logic       b1,
  input  logic       b0,
  output logic       q5,
  output logic       q4,
  output logic       q3,
  output logic       q2,
  output logic       q1,
  output logic       q0,
  output logic [5:0] sum_r
);

  operand_t w_a;
  operand_t w_b;
  operand_t w_s;
  sum_t     w_c;
  sum_t     w_sum;
  sum_t     r_sum;

  assign w_a = {a4, a3, a2, a1, a0};
  assign w_b = {b4, b3, b2, b1, b0};

`ifdef ADDER_CLA_EN
  operand_t w_g;
  operand_t w_p;

  assign w_g = w_a & w_b;
  assign w_p = w_a ^ w_b;
  assign w_c = cla_carry(w_g, w_p, 1'b0);
  assign w_s = w_p ^ w_c[OPW-1:0];
`else
  assign w_c[0] = 1'b0;

  for (genvar gi = 0; gi < OPW; gi++) begin : g_fa
    full_adder u_fa (
      .a  (w_a[gi]),
      .b  (w_b[gi]),
      .ci (w_c[gi]),
      .s  (w_s[gi]),
      .co (w_c[gi + 1])
    );
  end
`endif

  assign w_sum = {w_c[OPW], w_s};
  assign {q5, q4, q3, q2, q1, q0} = w_sum;
  assign sum_r = r_sum;

  // Capture the combinational sum each edge; async reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
    end else begin
      r_sum <= w_sum;
    end
  end

endmodule

// File: tb/tb_adder_5b.sv
// tb_adder_5b: directed table, exhaustive sweep and reset/latency
// sequences for adder_5b.
module tb_adder_5b;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic [5:0] q;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       a4, a3, a2, a1, a0;
  logic       b4, b3, b2, b1, b0;
  logic       q5, q4, q3, q2, q1, q0;
  logic [5:0] sum_r;

  int n_chk;
  int n_fail;

  adder_5b dut (
    .clk   (clk),
    .rst   (rst),
    .a4    (a4),
    .a3    (a3),
    .a2    (a2),
    .a1    (a1),
    .a0    (a0),
    .b4    (b4),
    .b3    (b3),
    .b2    (b2),
    .b1    (b1),
    .b0    (b0),
    .q5    (q5),
    .q4    (q4),
    .q3    (q3),
    .q2    (q2),
    .q1    (q1),
    .q0    (q0),
    .sum_r (sum_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] q_bus();
    return {q5, q4, q3, q2, q1, q0};
  endfunction

  task automatic set_ab(input logic [4:0] a, input logic [4:0] b);
    {a4, a3, a2, a1, a0} = a;
    {b4, b3, b2, b1, b0} = b;
  endtask

  task automatic check(
    input string      name,
    input logic [5:0] act,
    input logic [5:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (%b) expected %0d", name, act, act, exp);
    end
  endtask

  vec_t tbl[6];

  initial begin
    n_chk  = 0;
    n_fail = 0;

    tbl[0] = '{a: 5'd0,  b: 5'd0,  q: 6'd0};
    tbl[1] = '{a: 5'd1,  b: 5'd1,  q: 6'd2};
    tbl[2] = '{a: 5'd3,  b: 5'd3,  q: 6'd6};
    tbl[3] = '{a: 5'd31, b: 5'd1,  q: 6'd32};
    tbl[4] = '{a: 5'd31, b: 5'd31, q: 6'd62};
    tbl[5] = '{a: 5'd21, b: 5'd10, q: 6'd31};

    rst = 1'b1;
    set_ab(5'd0, 5'd0);
    #1;
    check("reset_sum_r", sum_r, 6'd0);
    @(posedge clk);
    #1;
    check("reset_hold", sum_r, 6'd0);

    for (int i = 0; i < 6; i++) begin
      set_ab(tbl[i].a, tbl[i].b);
      #1;
      check($sformatf("vec%0d_q", i), q_bus(), tbl[i].q);
    end

    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        logic [5:0] e;
        e = 6'(i) + 6'(j);
        set_ab(5'(i), 5'(j));
        #1;
        check($sformatf("exh_%0d_%0d", i, j), q_bus(), e);
      end
    end

    @(negedge clk);
    rst = 1'b0;
    set_ab(5'd3, 5'd4);
    @(posedge clk);
    #1;
    check("first_capture", sum_r, 6'd7);

    @(negedge clk);
    set_ab(5'd7, 5'd9);
    @(posedge clk);
    #1;
    check("capture_16", sum_r, 6'd16);

    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_sum_r", sum_r, 6'd0);
    check("rst_q_unaffected", q_bus(), 6'd16);
    #1;
    rst = 1'b0;
    #1;
    check("rst_release_no_edge", sum_r, 6'd0);
    @(posedge clk);
    #1;
    check("post_release", sum_r, 6'd16);

    @(negedge clk);
    set_ab(5'd2, 5'd5);
    #1;
    check("q_immediate", q_bus(), 6'd7);
    check("sum_r_holds", sum_r, 6'd16);
    @(posedge clk);
    #1;
    check("sum_r_after_edge", sum_r, 6'd7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
